// File: rtl/registro_universal_pkg.sv
// Shared encodings for the universal shift register: operation codes and burst FSM states.
// Optional arithmetic right shift is enabled by defining REGISTRO_ARITH_EN.
package registro_universal_pkg;

  typedef enum logic [1:0] {
    MODO_PUSH  = 2'b00,
    MODO_CYCLE = 2'b01,
    MODO_LOAD  = 2'b10,
    MODO_HOLD  = 2'b11
  } modo_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } estado_e;

  // Only PUSH and CYCLE move bits, so only they are worth a burst.
  function automatic logic es_desplazamiento(input modo_e m);
    return (m == MODO_PUSH) || (m == MODO_CYCLE);
  endfunction

endpackage

// File: rtl/registro_universal_if.sv
// Control/data bundle of the universal shift register; master drives commands, slave is the register.
// ARITH exists only when REGISTRO_ARITH_EN is defined.
interface registro_universal_if
  import registro_universal_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNTW  = 4
);
`ifdef REGISTRO_ARITH_EN
  logic             ARITH;
`endif
  logic             ENB;
  modo_e            MODO;
  logic             DIR;
  logic [STEP-1:0]  S_IN;
  logic [WIDTH-1:0] D;
  logic             START;
  logic [CNTW-1:0]  COUNT;
  logic [WIDTH-1:0] Q;
  logic [STEP-1:0]  S_OUT;
  logic             BUSY;
  logic             DONE;

  modport master (
`ifdef REGISTRO_ARITH_EN
    output ARITH,
`endif
    output ENB, MODO, DIR, S_IN, D, START, COUNT,
    input  Q, S_OUT, BUSY, DONE
  );

  modport slave (
`ifdef REGISTRO_ARITH_EN
    input  ARITH,
`endif
    input  ENB, MODO, DIR, S_IN, D, START, COUNT,
    output Q, S_OUT, BUSY, DONE
  );

endinterface

// File: rtl/registro_rafaga_ctrl.sv
// Burst controller: IDLE/RUN/FIN FSM, down-counter and latched op; tells the datapath what to do each edge.
// REGISTRO_ARITH_EN adds a latched ARITH flag alongside MODO/DIR.
module registro_rafaga_ctrl
  import registro_universal_pkg::*;
#(
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enb,
  input  modo_e           modo,
  input  logic            dir,
`ifdef REGISTRO_ARITH_EN
  input  logic            arith,
  output logic            op_arith,
`endif
  input  logic            start,
  input  logic [CNTW-1:0] count,
  output logic            busy,
  output logic            done,
  output modo_e           op_modo,
  output logic            op_dir,
  output logic            shift_en
);

  estado_e         state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  modo_e           modo_q, modo_d;
  logic            dir_q, dir_d;
`ifdef REGISTRO_ARITH_EN
  logic            arith_q, arith_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      modo_q  <= MODO_HOLD;
      dir_q   <= 1'b0;
`ifdef REGISTRO_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      dir_q   <= dir_d;
`ifdef REGISTRO_ARITH_EN
      arith_q <= arith_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    modo_d  = modo_q;
    dir_d   = dir_q;
`ifdef REGISTRO_ARITH_EN
    arith_d = arith_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enb && start) begin
          modo_d = modo;
          dir_d  = dir;
          cnt_d  = count;
`ifdef REGISTRO_ARITH_EN
          arith_d = arith;
`endif
          if (es_desplazamiento(modo) && (count != '0)) state_d = ST_RUN;
          else                                         state_d = ST_FIN;
        end
      end
      ST_RUN: begin
        if (enb) begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        // Leaves FIN regardless of ENB so DONE is always a single-cycle pulse.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_FIN);
  assign op_modo  = (state_q == ST_RUN) ? modo_q : modo;
  assign op_dir   = (state_q == ST_RUN) ? dir_q  : dir;
`ifdef REGISTRO_ARITH_EN
  assign op_arith = (state_q == ST_RUN) ? arith_q : arith;
`endif
  assign shift_en = enb && (((state_q == ST_IDLE) && !start) || (state_q == ST_RUN));

endmodule

// File: rtl/registro_universal.sv
// Universal shift register (PUSH/CYCLE/LOAD/HOLD, STEP bits per edge) with autonomous burst of COUNT shifts.
// REGISTRO_ARITH_EN enables arithmetic right shift on PUSH via the ARITH input.
module registro_universal
  import registro_universal_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNTW  = 4
) (
  input logic                  CLK,
  input logic                  RESET_N,
  registro_universal_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [STEP-1:0]  s_out_q, s_out_d;
  logic [STEP-1:0]  fill;
  modo_e            op_modo;
  logic             op_dir;
  logic             shift_en;
`ifdef REGISTRO_ARITH_EN
  logic             op_arith;
`endif

  registro_rafaga_ctrl #(.CNTW(CNTW)) u_ctrl (
    .clk      (CLK),
    .reset_n  (RESET_N),
    .enb      (bus.ENB),
    .modo     (bus.MODO),
    .dir      (bus.DIR),
`ifdef REGISTRO_ARITH_EN
    .arith    (bus.ARITH),
    .op_arith (op_arith),
`endif
    .start    (bus.START),
    .count    (bus.COUNT),
    .busy     (bus.BUSY),
    .done     (bus.DONE),
    .op_modo  (op_modo),
    .op_dir   (op_dir),
    .shift_en (shift_en)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      q_q     <= '0;
      s_out_q <= '0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  always_comb begin
`ifdef REGISTRO_ARITH_EN
    fill = op_arith ? {STEP{q_q[WIDTH-1]}} : bus.S_IN;
`else
    fill = bus.S_IN;
`endif
  end

  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    if (shift_en) begin
      case (op_modo)
        MODO_PUSH: begin
          if (!op_dir) begin
            s_out_d = q_q[WIDTH-1 -: STEP];
            q_d     = {q_q[WIDTH-STEP-1:0], bus.S_IN};
          end else begin
            s_out_d = q_q[STEP-1:0];
            q_d     = {fill, q_q[WIDTH-1:STEP]};
          end
        end
        MODO_CYCLE: begin
          s_out_d = '0;
          if (!op_dir) q_d = {q_q[WIDTH-STEP-1:0], q_q[WIDTH-1 -: STEP]};
          else         q_d = {q_q[STEP-1:0], q_q[WIDTH-1:STEP]};
        end
        MODO_LOAD: begin
          s_out_d = '0;
          q_d     = bus.D;
        end
        default: ;
      endcase
    end
  end

  assign bus.Q     = q_q;
  assign bus.S_OUT = s_out_q;

endmodule

// File: tb/tb_registro_universal.sv
// Directed bench for registro_universal: STEP=1 and STEP=2 instances, free-running ops and bursts.
module tb_registro_universal;
  import registro_universal_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  registro_universal_if #(.WIDTH(8), .STEP(1), .CNTW(4)) bus1 ();
  registro_universal_if #(.WIDTH(8), .STEP(2), .CNTW(4)) bus2 ();

  registro_universal #(.WIDTH(8), .STEP(1), .CNTW(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .bus(bus1)
  );
  registro_universal #(.WIDTH(8), .STEP(2), .CNTW(4)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .bus(bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input modo_e m, input logic d, input logic [7:0] dat,
                        input logic s, input logic st, input logic [3:0] c);
    bus1.MODO  = m;
    bus1.DIR   = d;
    bus1.D     = dat;
    bus1.S_IN  = s;
    bus1.START = st;
    bus1.COUNT = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.ENB = 1'b1;
    drive1(MODO_HOLD, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick(); tick();
    rst_n = 1'b1;
    drive1(MODO_LOAD, 1'b0, 8'hFF, 1'b1, 1'b0, 4'd0);
    tick();
    drive1(MODO_PUSH, 1'b0, 8'hFF, 1'b1, 1'b0, 4'd0);
    tick();
    rst_n = 1'b0;
    bus1.ENB = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus1.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", bus1.Q); end
    checks++;
    if (bus1.S_OUT !== 1'b0) begin errors++; $display("FAIL reset_sout got %b want 0", bus1.S_OUT); end
    checks++;
    if (bus1.BUSY !== 1'b0 || bus1.DONE !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus1.BUSY, bus1.DONE);
    end
    bus1.ENB = 1'b1;
  endtask

  task automatic test_load_push();
    drive1(MODO_LOAD, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd0);
    tick();
    drive1(MODO_PUSH, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus1.Q !== 8'h4B) begin errors++; $display("FAIL push_left_q got %h want 4b", bus1.Q); end
    checks++;
    if (bus1.S_OUT !== 1'b1) begin errors++; $display("FAIL push_left_sout got %b want 1", bus1.S_OUT); end
    drive1(MODO_PUSH, 1'b1, 8'h00, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus1.Q !== 8'hA5 || bus1.S_OUT !== 1'b1) begin
      errors++; $display("FAIL push_right got q=%h sout=%b want a5 1", bus1.Q, bus1.S_OUT);
    end
  endtask

  task automatic test_cycle_step2();
    bus2.ENB = 1'b1; bus2.START = 1'b0; bus2.COUNT = 4'd0; bus2.S_IN = 2'b11;
    bus2.MODO = MODO_LOAD; bus2.DIR = 1'b0; bus2.D = 8'hA5;
    tick();
    bus2.MODO = MODO_PUSH;
    tick();
    checks++;
    if (bus2.Q !== 8'h97 || bus2.S_OUT !== 2'b10) begin
      errors++; $display("FAIL push_step2 got q=%h sout=%b want 97 10", bus2.Q, bus2.S_OUT);
    end
    bus2.MODO = MODO_LOAD;
    tick();
    bus2.MODO = MODO_CYCLE; bus2.DIR = 1'b1;
    tick();
    checks++;
    if (bus2.Q !== 8'h69 || bus2.S_OUT !== 2'b00) begin
      errors++; $display("FAIL cycle_step2 got q=%h sout=%b want 69 00", bus2.Q, bus2.S_OUT);
    end
    bus2.MODO = MODO_HOLD;
    tick();
    checks++;
    if (bus2.Q !== 8'h69) begin errors++; $display("FAIL hold_step2 got %h want 69", bus2.Q); end
    bus2.ENB = 1'b0;
  endtask

  task automatic test_burst_cycle();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    drive1(MODO_LOAD, 1'b0, 8'h81, 1'b0, 1'b0, 4'd0);
    tick();
    drive1(MODO_CYCLE, 1'b0, 8'hFF, 1'b0, 1'b1, 4'd3);
    tick();
    checks++;
    if (bus1.Q !== 8'h81 || bus1.BUSY !== 1'b1 || bus1.DONE !== 1'b0) begin
      errors++; $display("FAIL burst_start got q=%h busy=%b done=%b want 81 1 0", bus1.Q, bus1.BUSY, bus1.DONE);
    end
    drive1(MODO_LOAD, 1'b1, 8'hFF, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus1.Q !== exp_q[i] || bus1.BUSY !== (i < 2) || bus1.DONE !== (i == 2)) begin
        errors++;
        $display("FAIL burst_step%0d got q=%h busy=%b done=%b want %h %b %b",
                 i, bus1.Q, bus1.BUSY, bus1.DONE, exp_q[i], (i < 2), (i == 2));
      end
    end
    bus1.MODO = MODO_HOLD;
    tick();
    checks++;
    if (bus1.Q !== 8'h0C || bus1.DONE !== 1'b0 || bus1.BUSY !== 1'b0) begin
      errors++; $display("FAIL burst_end got q=%h busy=%b done=%b want 0c 0 0", bus1.Q, bus1.BUSY, bus1.DONE);
    end
  endtask

  task automatic test_enb_stall();
    logic [7:0] exp_q [6];
    logic       exp_busy [6];
    logic       exp_done [6];
    logic       enb_seq [6];
    exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h04; exp_q[3] = 8'h04; exp_q[4] = 8'h08; exp_q[5] = 8'h10;
    exp_busy[0] = 1; exp_busy[1] = 1; exp_busy[2] = 1; exp_busy[3] = 1; exp_busy[4] = 1; exp_busy[5] = 0;
    exp_done[0] = 0; exp_done[1] = 0; exp_done[2] = 0; exp_done[3] = 0; exp_done[4] = 0; exp_done[5] = 1;
    enb_seq[0] = 1; enb_seq[1] = 1; enb_seq[2] = 0; enb_seq[3] = 0; enb_seq[4] = 1; enb_seq[5] = 1;
    drive1(MODO_LOAD, 1'b0, 8'h01, 1'b0, 1'b0, 4'd0);
    tick();
    drive1(MODO_PUSH, 1'b0, 8'h00, 1'b0, 1'b1, 4'd4);
    tick();
    drive1(MODO_CYCLE, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      bus1.ENB = enb_seq[i];
      tick();
      checks++;
      if (bus1.Q !== exp_q[i] || bus1.BUSY !== exp_busy[i] || bus1.DONE !== exp_done[i]) begin
        errors++;
        $display("FAIL stall_step%0d got q=%h busy=%b done=%b want %h %b %b",
                 i, bus1.Q, bus1.BUSY, bus1.DONE, exp_q[i], exp_busy[i], exp_done[i]);
      end
    end
    drive1(MODO_HOLD, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    drive1(MODO_PUSH, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0);
    tick();
    checks++;
    if (bus1.Q !== 8'h10 || bus1.BUSY !== 1'b0 || bus1.DONE !== 1'b1) begin
      errors++; $display("FAIL count0 got q=%h busy=%b done=%b want 10 0 1", bus1.Q, bus1.BUSY, bus1.DONE);
    end
    tick();
    checks++;
    if (bus1.Q !== 8'h10 || bus1.BUSY !== 1'b0 || bus1.DONE !== 1'b0) begin
      errors++; $display("FAIL fin_start_ignored got q=%h busy=%b done=%b want 10 0 0", bus1.Q, bus1.BUSY, bus1.DONE);
    end
    drive1(MODO_HOLD, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    drive1(MODO_LOAD, 1'b0, 8'h5A, 1'b0, 1'b0, 4'd0);
    tick();
    drive1(MODO_PUSH, 1'b0, 8'h00, 1'b1, 1'b1, 4'd5);
    tick();
    bus1.START = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus1.Q !== 8'h00 || bus1.BUSY !== 1'b0 || bus1.DONE !== 1'b0) begin
      errors++; $display("FAIL abort got q=%h busy=%b done=%b want 00 0 0", bus1.Q, bus1.BUSY, bus1.DONE);
    end
    bus1.MODO = MODO_HOLD;
    tick(); tick();
    checks++;
    if (bus1.DONE !== 1'b0 || bus1.BUSY !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got busy=%b done=%b want 0 0", bus1.BUSY, bus1.DONE);
    end
  endtask

  task automatic test_arith();
    logic [7:0] exp;
`ifdef REGISTRO_ARITH_EN
    exp = 8'hC8;
    bus1.ARITH = 1'b1;
`else
    exp = 8'h48;
`endif
    drive1(MODO_LOAD, 1'b0, 8'h90, 1'b0, 1'b0, 4'd0);
    tick();
    drive1(MODO_PUSH, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus1.Q !== exp || bus1.S_OUT !== 1'b0) begin
      errors++; $display("FAIL push_right_arith got q=%h sout=%b want %h 0", bus1.Q, bus1.S_OUT, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef REGISTRO_ARITH_EN
    bus1.ARITH = 1'b0;
    bus2.ARITH = 1'b0;
`endif
    bus2.ENB = 1'b0; bus2.MODO = MODO_HOLD; bus2.DIR = 1'b0; bus2.S_IN = '0;
    bus2.D = '0; bus2.START = 1'b0; bus2.COUNT = '0;
    bus1.ENB = 1'b0;
    drive1(MODO_HOLD, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    test_reset();
    test_load_push();
    test_cycle_step2();
    test_burst_cycle();
    test_enb_stall();
    test_reset_mid_burst();
    test_arith();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
